// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the single-issue MIPS core. Owns the program
//   counter, presents it as the word address of a combinational instruction
//   memory and captures the returned word into the IF/ID pipeline register.
//   Supports decode stalls, branch/jump redirect (with IF/ID flush) and halt.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_addr        word address to instruction memory (the PC register)
//   imem_instr       instruction word returned combinationally for imem_addr
//   stall            hold PC and IF/ID contents
//   redirect         load redirect_target into PC and flush IF/ID
//   redirect_target  new PC (word address)
//   halt_req         stop fetching after the current capture
//   ifid_instr       registered instruction for decode (0 = NOP on flush)
//   ifid_pc          PC of ifid_instr
//   ifid_pc_plus1    ifid_pc + 1, wrapping
//   ifid_valid       ifid_* carry a real instruction
//   halted           fetch FSM is in HALT
//   fetch_count      saturating count of delivered instructions
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt_req,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic              ifid_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Sequential PC wraps modulo 2^ADDR_W.
    assign pc_next_seq = pc + PC_ONE;
    assign imem_addr   = pc;

    // IF -> IF/ID boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= PC_RST;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
            halted        <= 1'b0;
            fetch_count   <= '0;
        end else begin
            case (state)
                BOOT: begin
                    // One dead cycle after reset release; memory address settles.
                    ifid_valid <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        // Redirect beats stall: the wrong-path word must not survive.
                        pc         <= redirect_target;
                        ifid_instr <= '0;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr    <= imem_instr;
                        ifid_pc       <= pc;
                        ifid_pc_plus1 <= pc_next_seq;
                        ifid_valid    <= 1'b1;
                        pc            <= pc_next_seq;
                        fetch_count   <= sat_inc(fetch_count);
                        // halt_req still delivers this edge's instruction.
                        if (halt_req) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (redirect) begin
                        pc         <= redirect_target;
                        ifid_instr <= '0;
                        ifid_valid <= 1'b0;
                        halted     <= 1'b0;
                        state      <= RUN;
                    end else if (!stall) begin
                        // A stalled decoder keeps the last instruction until it consumes it.
                        ifid_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule
